layer_step_sequencer: RTL and testbench

Time-step controller for one neuron layer during a fixed-window inference run. Per run it:
- pulls NUM_STEPS input spike frames over a valid/ready handshake;
- presents each frame to the layer for exactly one cycle;
- samples the layer's output spikes after a fixed pipeline latency and accumulates per-neuron spike counts;
- reports the winning neuron (argmax) on a valid/ready result port.

It sits between the input encoder and the layer, and clears layer state at the start of each run.

---
 rtl/snn_seq_pkg.sv | 30 +++
 rtl/spike_argmax.sv | 74 +++++++
 rtl/layer_step_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_layer_step_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : snn_seq_pkg
// Purpose : Shared state encoding and width helpers for the layer step
//           sequencer and its argmax scanner.
// Rev     : 1.0  initial release
// ============================================================================
package snn_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_FETCH  = 3'd2,
        S_FIRE   = 3'd3,
        S_WAIT   = 3'd4,
        S_SAMPLE = 3'd5,
        S_ARGMAX = 3'd6,
        S_DONE   = 3'd7
    } seq_state_e;

    function automatic int cnt_w(input int steps);
        return $clog2(steps + 1);
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spike_argmax.sv
`default_nettype none
// ============================================================================
// Module  : spike_argmax
// Purpose : Sequential argmax over a packed count array, one entry per cycle.
//           Strict compare keeps the lowest index on ties.
// Rev     : 1.0  initial release
// ============================================================================
module spike_argmax
    import snn_seq_pkg::*;
#(
    parameter int NEURON_COUNT = 10,
    parameter int CNT_W        = 6,
    parameter int IDX_W        = idx_w(NEURON_COUNT)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_start,
    input  logic [NEURON_COUNT*CNT_W-1:0] i_counts,
    output logic                          o_done,
    output logic [IDX_W-1:0]              o_index,
    output logic [CNT_W-1:0]              o_max
);

    localparam logic [IDX_W-1:0] c_LAST = IDX_W'(NEURON_COUNT - 1);

    logic [CNT_W-1:0] w_cnt [NEURON_COUNT];
    logic [CNT_W-1:0] w_cur;
    logic             w_take;

    logic             r_active;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_best_idx;
    logic [CNT_W-1:0] r_best;

    generate
        for (genvar g = 0; g < NEURON_COUNT; g++) begin : g_unpack
            assign w_cnt[g] = i_counts[g*CNT_W +: CNT_W];
        end
    endgenerate

    always_comb begin
        w_cur = w_cnt[r_idx];
    end

    // Outputs fold in the entry under test so the done cycle carries the final answer.
    assign w_take  = r_active && (w_cur > r_best);
    assign o_index = w_take ? r_idx : r_best_idx;
    assign o_max   = w_take ? w_cur : r_best;
    assign o_done  = r_active && (r_idx == c_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active   <= 1'b0;
            r_idx      <= '0;
            r_best_idx <= '0;
            r_best     <= '0;
        end else if (i_start) begin
            r_active   <= 1'b1;
            r_idx      <= '0;
            r_best_idx <= '0;
            r_best     <= '0;
        end else if (r_active) begin
            r_best_idx <= o_index;
            r_best     <= o_max;
            if (o_done) begin
                r_active <= 1'b0;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/layer_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : layer_step_sequencer
// Purpose : Runs one fixed-window inference over a neuron layer: fetch frame,
//           fire, wait out the layer latency, accumulate spikes, then argmax.
//           Optional early exit enabled by macro SEQ_EARLY_EXIT_EN.
// Rev     : 1.0  initial release
// ============================================================================
module layer_step_sequencer
    import snn_seq_pkg::*;
#(
    parameter int INPUT_COUNT  = 16,
    parameter int NEURON_COUNT = 10,
    parameter int NUM_STEPS    = 32,
    parameter int LAYER_LAT    = 2,
    parameter int EXIT_COUNT   = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    output logic                             busy,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [INPUT_COUNT-1:0]           in_spikes,
    output logic                             layer_clr,
    output logic [INPUT_COUNT-1:0]           layer_in_spikes,
    input  logic [NEURON_COUNT-1:0]          layer_out_spikes,
    output logic                             result_valid,
    input  logic                             result_ready,
    output logic [idx_w(NEURON_COUNT)-1:0]   result_class,
    output logic [cnt_w(NUM_STEPS)-1:0]      result_count,
    output logic [cnt_w(NUM_STEPS)-1:0]      result_steps
);

    localparam int c_CNT_W = cnt_w(NUM_STEPS);
    localparam int c_IDX_W = idx_w(NEURON_COUNT);
    localparam int c_LAT_W = cnt_w(LAYER_LAT);
    localparam logic [c_LAT_W-1:0] c_LAT_LAST = c_LAT_W'((LAYER_LAT > 1) ? LAYER_LAT - 2 : 0);
    localparam logic [c_CNT_W-1:0] c_STEPS    = c_CNT_W'(NUM_STEPS);

    seq_state_e r_state;
    seq_state_e w_state_nxt;

    logic [INPUT_COUNT-1:0]          r_frame;
    logic [c_CNT_W-1:0]              r_step;
    logic [c_CNT_W-1:0]              w_step_nxt;
    logic [c_LAT_W-1:0]              r_lat;
    logic [c_CNT_W-1:0]              r_count     [NEURON_COUNT];
    logic [c_CNT_W-1:0]              w_count_nxt [NEURON_COUNT];
    logic [NEURON_COUNT*c_CNT_W-1:0] w_counts_flat;
    logic                            w_exit;
    logic                            w_am_start;
    logic                            w_am_done;
    logic [c_IDX_W-1:0]              w_am_index;
    logic [c_CNT_W-1:0]              w_am_max;
    logic [c_IDX_W-1:0]              r_res_class;
    logic [c_CNT_W-1:0]              r_res_count;
    logic [c_CNT_W-1:0]              r_res_steps;

    generate
        for (genvar g = 0; g < NEURON_COUNT; g++) begin : g_count
            assign w_count_nxt[g] = r_count[g] + c_CNT_W'(layer_out_spikes[g]);
            assign w_counts_flat[g*c_CNT_W +: c_CNT_W] = r_count[g];
        end
    endgenerate

    assign w_step_nxt = r_step + 1'b1;

`ifdef SEQ_EARLY_EXIT_EN
    always_comb begin
        w_exit = 1'b0;
        for (int n = 0; n < NEURON_COUNT; n++) begin
            if (int'(w_count_nxt[n]) >= EXIT_COUNT) begin
                w_exit = 1'b1;
            end
        end
    end
`else
    assign w_exit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start)    w_state_nxt = S_CLEAR;
            S_CLEAR:                w_state_nxt = S_FETCH;
            S_FETCH:  if (in_valid) w_state_nxt = S_FIRE;
            S_FIRE:                 w_state_nxt = (LAYER_LAT > 1) ? S_WAIT : S_SAMPLE;
            S_WAIT:   if (r_lat == c_LAT_LAST) w_state_nxt = S_SAMPLE;
            S_SAMPLE: w_state_nxt = ((w_step_nxt == c_STEPS) || w_exit) ? S_ARGMAX : S_FETCH;
            S_ARGMAX: if (w_am_done)    w_state_nxt = S_DONE;
            S_DONE:   if (result_ready) w_state_nxt = S_IDLE;
            default:                    w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy            = 1'b0;
        in_ready        = 1'b0;
        layer_clr       = 1'b0;
        layer_in_spikes = '0;
        result_valid    = 1'b0;
        w_am_start      = 1'b0;
        case (r_state)
            S_IDLE:   busy = 1'b0;
            S_CLEAR:  begin busy = 1'b1; layer_clr = 1'b1; end
            S_FETCH:  begin busy = 1'b1; in_ready = 1'b1; end
            S_FIRE:   begin busy = 1'b1; layer_in_spikes = r_frame; end
            S_SAMPLE: begin busy = 1'b1; w_am_start = (w_state_nxt == S_ARGMAX); end
            S_DONE:   begin busy = 1'b1; result_valid = 1'b1; end
            default:  busy = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame     <= '0;
            r_step      <= '0;
            r_lat       <= '0;
            r_res_class <= '0;
            r_res_count <= '0;
            r_res_steps <= '0;
            for (int n = 0; n < NEURON_COUNT; n++) begin
                r_count[n] <= '0;
            end
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_step <= '0;
                    r_lat  <= '0;
                    for (int n = 0; n < NEURON_COUNT; n++) begin
                        r_count[n] <= '0;
                    end
                end
                S_FETCH: if (in_valid) r_frame <= in_spikes;
                S_FIRE:  r_lat <= '0;
                S_WAIT:  r_lat <= r_lat + 1'b1;
                S_SAMPLE: begin
                    r_step <= w_step_nxt;
                    for (int n = 0; n < NEURON_COUNT; n++) begin
                        r_count[n] <= w_count_nxt[n];
                    end
                end
                S_ARGMAX: begin
                    if (w_am_done) begin
                        r_res_class <= w_am_index;
                        r_res_count <= w_am_max;
                        r_res_steps <= r_step;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result_class = r_res_class;
    assign result_count = r_res_count;
    assign result_steps = r_res_steps;

    spike_argmax #(
        .NEURON_COUNT (NEURON_COUNT),
        .CNT_W        (c_CNT_W),
        .IDX_W        (c_IDX_W)
    ) u_argmax (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_am_start),
        .i_counts (w_counts_flat),
        .o_done   (w_am_done),
        .o_index  (w_am_index),
        .o_max    (w_am_max)
    );

endmodule
`default_nettype wire

// File: tb/tb_layer_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_layer_step_sequencer
// Purpose : Randomized self-checking bench for layer_step_sequencer with a
//           behavioural layer and result model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_layer_step_sequencer;

    localparam int IC = 16;
    localparam int NC = 4;
    localparam int NS = 4;
    localparam int LL = 2;
    localparam int EC = 2;
    localparam int CW = $clog2(NS + 1);
    localparam int IW = $clog2(NC);
`ifdef SEQ_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    typedef logic [NC-1:0] plan_t [NS];
    typedef struct {
        int lat;
        int cls;
        int cnt;
        int steps;
        int clr;
        bit stable;
        bit dropped;
        bit frames_ok;
        bit timeout;
    } obs_t;

    logic          clk;
    logic          rst;
    logic          start;
    logic          busy;
    logic          in_valid;
    logic          in_ready;
    logic [IC-1:0] in_spikes;
    logic          layer_clr;
    logic [IC-1:0] layer_in_spikes;
    logic [NC-1:0] layer_out_spikes = '0;
    logic          result_valid;
    logic          result_ready;
    logic [IW-1:0] result_class;
    logic [CW-1:0] result_count;
    logic [CW-1:0] result_steps;

    int n_cmp = 0;
    int n_bad = 0;

    layer_step_sequencer #(
        .INPUT_COUNT  (IC),
        .NEURON_COUNT (NC),
        .NUM_STEPS    (NS),
        .LAYER_LAT    (LL),
        .EXIT_COUNT   (EC)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .busy             (busy),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_spikes        (in_spikes),
        .layer_clr        (layer_clr),
        .layer_in_spikes  (layer_in_spikes),
        .layer_out_spikes (layer_out_spikes),
        .result_valid     (result_valid),
        .result_ready     (result_ready),
        .result_class     (result_class),
        .result_count     (result_count),
        .result_steps     (result_steps)
    );

    always #5 clk = ~clk;

    // Behavioural layer: spikes appear only in the cycle LL after the frame is fired.
    logic [NC-1:0] q_plan  [$];
    logic [IC-1:0] q_fired [$];
    logic [NC-1:0] cur_plan   = '0;
    int            cyc        = 0;
    int            sample_cyc = -1;
    int            clr_pulses = 0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            sample_cyc = -1;
        end else begin
            if (in_valid && in_ready) begin
                sample_cyc = cyc + 1 + LL;
                cur_plan   = (q_plan.size() > 0) ? q_plan.pop_front() : '0;
            end
            if (layer_clr) clr_pulses = clr_pulses + 1;
            if (layer_in_spikes != '0) q_fired.push_back(layer_in_spikes);
        end
        layer_out_spikes = (cyc == sample_cyc) ? cur_plan : NC'($urandom);
    end

    function automatic void ref_model(input plan_t plan, output int cls, output int cnt, output int steps);
        int c [NC];
        bool_loop: begin end
        for (int n = 0; n < NC; n++) c[n] = 0;
        steps = 0;
        for (int s = 0; s < NS; s++) begin
            bit hit;
            hit = 1'b0;
            for (int n = 0; n < NC; n++) begin
                c[n] = c[n] + int'(plan[s][n]);
                if (c[n] >= EC) hit = 1'b1;
            end
            steps = s + 1;
            if (EE && hit) break;
        end
        cls = 0;
        cnt = c[0];
        for (int n = 1; n < NC; n++) begin
            if (c[n] > cnt) begin
                cls = n;
                cnt = c[n];
            end
        end
    endfunction

    task automatic do_run(input plan_t plan, input int gap, input int rdy_delay, input bit spam, output obs_t o);
        logic [IC-1:0] sent [$];
        logic [IC-1:0] fr;
        bit            fin;
        bit            hs;
        int            acc;
        int            clr0;
        o.lat = 0; o.cls = 0; o.cnt = 0; o.steps = 0; o.clr = 0;
        o.stable = 1'b1; o.dropped = 1'b0; o.frames_ok = 1'b0; o.timeout = 1'b0;
        q_plan.delete();
        for (int s = 0; s < NS; s++) q_plan.push_back(plan[s]);
        q_fired.delete();
        clr0 = clr_pulses;
        fin  = 1'b0;
        acc  = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        o.lat = 1;
        fork
            begin
                while (!fin && acc < NS) begin
                    for (int g = 0; g < gap && !fin; g++) begin
                        in_valid = 1'b0;
                        if (spam) begin start = 1'($urandom); result_ready = 1'($urandom); end
                        @(posedge clk); #1;
                    end
                    fr = IC'($urandom);
                    if (fr == '0) fr = 1;
                    in_spikes = fr;
                    in_valid  = 1'b1;
                    hs = 1'b0;
                    while (!fin && !hs) begin
                        @(negedge clk);
                        hs = in_ready;
                        if (spam && !fin) begin start = 1'($urandom); result_ready = 1'($urandom); end
                        @(posedge clk); #1;
                    end
                    if (hs) begin
                        sent.push_back(fr);
                        acc++;
                    end
                    in_valid = 1'b0;
                end
                in_valid = 1'b0;
            end
            begin
                while (!result_valid && o.lat < 3000) begin
                    @(posedge clk); #1;
                    o.lat++;
                end
                fin          = 1'b1;
                start        = 1'b0;
                result_ready = 1'b0;
            end
        join
        o.timeout = !result_valid;
        o.cls     = int'(result_class);
        o.cnt     = int'(result_count);
        o.steps   = int'(result_steps);
        for (int i = 0; i < rdy_delay; i++) begin
            @(posedge clk); #1;
            if (!result_valid || int'(result_class) != o.cls || int'(result_count) != o.cnt || int'(result_steps) != o.steps)
                o.stable = 1'b0;
        end
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        o.dropped = !result_valid && !busy;
        o.clr     = clr_pulses - clr0;
        o.frames_ok = (sent.size() == q_fired.size()) && (sent.size() == o.steps);
        for (int i = 0; i < sent.size() && i < q_fired.size(); i++) begin
            if (sent[i] !== q_fired[i]) o.frames_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset busy: got %b want 0", busy); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset in_ready: got %b want 0", in_ready); end
        n_cmp++; if (layer_clr !== 1'b0) begin n_bad++; $display("FAIL reset layer_clr: got %b want 0", layer_clr); end
        n_cmp++; if (layer_in_spikes !== '0) begin n_bad++; $display("FAIL reset layer_in: got %h want 0", layer_in_spikes); end
        n_cmp++; if (result_valid !== 1'b0) begin n_bad++; $display("FAIL reset result_valid: got %b want 0", result_valid); end
        n_cmp++; if ({result_class, result_count, result_steps} !== '0) begin n_bad++; $display("FAIL reset result: got %0d/%0d/%0d want 0/0/0", result_class, result_count, result_steps); end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle busy: got %b want 0", busy); end
    endtask

    task automatic test_basic();
        plan_t p; obs_t o;
        int e_cls, e_cnt, e_steps, e_lat;
        for (int s = 0; s < NS; s++) p[s] = 4'b0100;
        ref_model(p, e_cls, e_cnt, e_steps);
        e_lat = 1 + e_steps * (LL + 2) + NC + 1;
        do_run(p, 0, 0, 1'b0, o);
        n_cmp++; if (o.timeout !== 1'b0) begin n_bad++; $display("FAIL basic timeout: got %b want 0", o.timeout); end
        n_cmp++; if (o.lat !== e_lat) begin n_bad++; $display("FAIL basic latency: got %0d want %0d", o.lat, e_lat); end
        n_cmp++; if (o.cls !== e_cls) begin n_bad++; $display("FAIL basic class: got %0d want %0d", o.cls, e_cls); end
        n_cmp++; if (o.cnt !== e_cnt) begin n_bad++; $display("FAIL basic count: got %0d want %0d", o.cnt, e_cnt); end
        n_cmp++; if (o.steps !== e_steps) begin n_bad++; $display("FAIL basic steps: got %0d want %0d", o.steps, e_steps); end
        n_cmp++; if (o.clr !== 1) begin n_bad++; $display("FAIL basic clr pulses: got %0d want 1", o.clr); end
        n_cmp++; if (o.frames_ok !== 1'b1) begin n_bad++; $display("FAIL basic frames: got %b want 1", o.frames_ok); end
        n_cmp++; if (o.dropped !== 1'b1) begin n_bad++; $display("FAIL basic valid drop: got %b want 1", o.dropped); end
    endtask

    task automatic test_reset_mid_run();
        plan_t p; obs_t o;
        int e_cls, e_cnt, e_steps;
        q_plan.delete();
        for (int s = 0; s < NS; s++) q_plan.push_back('1);
        q_fired.delete();
        in_spikes = 16'hA5A5;
        in_valid  = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 200 && q_fired.size() < 3; i++) @(negedge clk);
        n_cmp++; if (q_fired.size() !== 3) begin n_bad++; $display("FAIL midrun reach step3: got %0d frames want 3", q_fired.size()); end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrun busy: got %b want 0", busy); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL midrun in_ready: got %b want 0", in_ready); end
        n_cmp++; if ({layer_clr, layer_in_spikes, result_valid} !== '0) begin n_bad++; $display("FAIL midrun layer outputs: got clr=%b in=%h valid=%b want 0", layer_clr, layer_in_spikes, result_valid); end
        n_cmp++; if ({result_class, result_count, result_steps} !== '0) begin n_bad++; $display("FAIL midrun result: got %0d/%0d/%0d want 0/0/0", result_class, result_count, result_steps); end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int s = 0; s < NS; s++) p[s] = (s == 0) ? 4'b1000 : 4'b0001;
        ref_model(p, e_cls, e_cnt, e_steps);
        do_run(p, 1, 2, 1'b0, o);
        n_cmp++; if (o.cls !== e_cls || o.cnt !== e_cnt) begin n_bad++; $display("FAIL post-reset run: got %0d/%0d want %0d/%0d", o.cls, o.cnt, e_cls, e_cnt); end
        n_cmp++; if (o.steps !== e_steps) begin n_bad++; $display("FAIL post-reset steps: got %0d want %0d", o.steps, e_steps); end
    endtask

    task automatic test_tie();
        plan_t p; obs_t o;
        int e_cls, e_cnt, e_steps;
        for (int s = 0; s < NS; s++) p[s] = 4'b1010;
        ref_model(p, e_cls, e_cnt, e_steps);
        do_run(p, 0, 1, 1'b0, o);
        n_cmp++; if (o.cls !== e_cls) begin n_bad++; $display("FAIL tie class: got %0d want %0d", o.cls, e_cls); end
        n_cmp++; if (o.cnt !== e_cnt) begin n_bad++; $display("FAIL tie count: got %0d want %0d", o.cnt, e_cnt); end
        n_cmp++; if (o.steps !== e_steps) begin n_bad++; $display("FAIL tie steps: got %0d want %0d", o.steps, e_steps); end
    endtask

    task automatic test_zero_activity();
        plan_t p; obs_t o;
        for (int s = 0; s < NS; s++) p[s] = '0;
        do_run(p, 0, 0, 1'b0, o);
        n_cmp++; if (o.cls !== 0 || o.cnt !== 0) begin n_bad++; $display("FAIL zero result: got %0d/%0d want 0/0", o.cls, o.cnt); end
        n_cmp++; if (o.steps !== NS) begin n_bad++; $display("FAIL zero steps: got %0d want %0d", o.steps, NS); end
        n_cmp++; if (o.clr !== 1) begin n_bad++; $display("FAIL zero clr pulses: got %0d want 1", o.clr); end
    endtask

    task automatic test_backpressure();
        plan_t p; obs_t o;
        int e_cls, e_cnt, e_steps;
        for (int s = 0; s < NS; s++) p[s] = NC'($urandom);
        ref_model(p, e_cls, e_cnt, e_steps);
        do_run(p, 5, 10, 1'b1, o);
        n_cmp++; if (o.timeout !== 1'b0) begin n_bad++; $display("FAIL bp timeout: got %b want 0", o.timeout); end
        n_cmp++; if (o.cls !== e_cls || o.cnt !== e_cnt || o.steps !== e_steps) begin n_bad++; $display("FAIL bp result: got %0d/%0d/%0d want %0d/%0d/%0d", o.cls, o.cnt, o.steps, e_cls, e_cnt, e_steps); end
        n_cmp++; if (o.stable !== 1'b1) begin n_bad++; $display("FAIL bp result stable: got %b want 1", o.stable); end
        n_cmp++; if (o.frames_ok !== 1'b1) begin n_bad++; $display("FAIL bp frames: got %b want 1", o.frames_ok); end
        n_cmp++; if (o.clr !== 1) begin n_bad++; $display("FAIL bp clr pulses: got %0d want 1", o.clr); end
        n_cmp++; if (o.dropped !== 1'b1) begin n_bad++; $display("FAIL bp valid drop: got %b want 1", o.dropped); end
    endtask

    task automatic test_random();
        plan_t p; obs_t o;
        int e_cls, e_cnt, e_steps;
        for (int it = 0; it < 8; it++) begin
            for (int s = 0; s < NS; s++) p[s] = NC'($urandom);
            ref_model(p, e_cls, e_cnt, e_steps);
            do_run(p, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'($urandom), o);
            n_cmp++; if (o.cls !== e_cls || o.cnt !== e_cnt) begin n_bad++; $display("FAIL rand%0d result: got %0d/%0d want %0d/%0d", it, o.cls, o.cnt, e_cls, e_cnt); end
            n_cmp++; if (o.steps !== e_steps) begin n_bad++; $display("FAIL rand%0d steps: got %0d want %0d", it, o.steps, e_steps); end
            n_cmp++; if (o.frames_ok !== 1'b1 || o.stable !== 1'b1) begin n_bad++; $display("FAIL rand%0d frames/stable: got %b/%b want 1/1", it, o.frames_ok, o.stable); end
        end
    endtask

    initial begin
        clk          = 1'b0;
        rst          = 1'b1;
        start        = 1'b0;
        in_valid     = 1'b0;
        in_spikes    = '0;
        result_ready = 1'b0;
        test_reset();
        test_basic();
        test_reset_mid_run();
        test_tie();
        test_zero_activity();
        test_backpressure();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
